// File: rtl/life_pkg.sv
// life_pkg: shared state encoding, default grid geometry and the cell-index helper
package life_pkg;
    localparam int DEF_ROWS = 16;
    localparam int DEF_COLS = 16;
    localparam int DEF_GW   = 16;
    typedef enum logic [2:0] {IDLE, FILL, LOAD, RUN, HOLD} state_t;
    function automatic int cell_idx(input int x, input int y, input int cols = DEF_COLS);
        return cols * x + y;
    endfunction
endpackage

// File: rtl/life_row_popcount.sv
// life_row_popcount: combinational population count of one row word
//   row   in  W            row word
//   count out clog2(W+1)   number of set bits
module life_row_popcount #(
    parameter int W = 16
) (
    input  logic [W-1:0]             row,
    output logic [$clog2(W+1)-1:0]   count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) count = count + {{($clog2(W+1)-1){1'b0}}, row[i]};
    end
endmodule

// File: rtl/life_grid_writer.sv
// life_grid_writer: streams row words into a shadow grid, loads the Life array, runs it N generations, then freezes it
//   clk/resetn             clock, synchronous active-low reset
//   row_valid/row_ready    host row-word handshake; row_data bit y = cell (x,y), gens sampled with the last row
//   grid_in                array out_data, fed back through in_data to freeze it in HOLD
//   load/in_data           array parallel-load strobe and data (cell (x,y) at bit COLS*x+y)
//   busy/done/gens_left    status: busy in FILL/LOAD/RUN, done pulses on HOLD entry, generations remaining
//   live_count             live cells of the last loaded frame; built only with LIFE_WRITER_POPCOUNT_EN, else 0
module life_grid_writer
    import life_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int GW   = DEF_GW
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            row_valid,
    output logic                            row_ready,
    input  logic [COLS-1:0]                 row_data,
    input  logic [GW-1:0]                   gens,
    input  logic [ROWS*COLS-1:0]            grid_in,
    output logic                            load,
    output logic [ROWS*COLS-1:0]            in_data,
    output logic                            busy,
    output logic                            done,
    output logic [GW-1:0]                   gens_left,
    output logic [$clog2(ROWS*COLS+1)-1:0]  live_count
);
    localparam int RW = $clog2(ROWS);
    localparam int LW = $clog2(ROWS*COLS+1);
    state_t               state, nxt;
    logic [RW-1:0]        r;
    logic [ROWS*COLS-1:0] shadow;
    logic [GW-1:0]        gens_q;
    logic                 acc, last;
    assign acc  = row_valid && row_ready;
    assign last = acc && r == RW'(ROWS-1);
    always_ff @(posedge clk) state <= !resetn ? IDLE : nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = acc ? FILL : IDLE;
            FILL:    nxt = last ? LOAD : FILL;
            LOAD:    nxt = gens_q == '0 ? HOLD : RUN;
            RUN:     nxt = gens_left == GW'(1) ? HOLD : RUN;
            HOLD:    nxt = acc ? FILL : HOLD;
            default: nxt = IDLE;
        endcase
    end
    // HOLD feeds the array its own state so it stays frozen
    always_comb begin
        row_ready = state inside {IDLE, FILL, HOLD};
        load      = state != RUN;
        in_data   = state == HOLD ? grid_in : shadow;
        busy      = state inside {FILL, LOAD, RUN};
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r         <= '0;
            shadow    <= '0;
            gens_q    <= '0;
            gens_left <= '0;
            done      <= 1'b0;
        end else begin
            if (acc) begin
                shadow[cell_idx(int'(r), 0, COLS) +: COLS] <= row_data;
                r <= last ? '0 : r + 1'b1;
            end
            if (last) gens_q <= gens;
            gens_left <= nxt == RUN ? (state == RUN ? gens_left - 1'b1 : gens_q) : '0;
            done      <= nxt == HOLD && state != HOLD;
        end
    end
`ifdef LIFE_WRITER_POPCOUNT_EN
    localparam int PW = $clog2(COLS+1);
    logic [PW-1:0] row_pc;
    logic [LW-1:0] run_pc;
    life_row_popcount #(.W(COLS)) u_pc (.row(row_data), .count(row_pc));
    // row 0 restarts the running sum; the last row publishes the frame total
    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_pc     <= '0;
            live_count <= '0;
        end else if (acc) begin
            run_pc <= (r == '0 ? '0 : run_pc) + LW'(row_pc);
            if (last) live_count <= run_pc + LW'(row_pc);
        end
    end
`else
    assign live_count = LW'(0);
`endif
endmodule
